// File: rtl/gcd_req_queue_if.sv
// Handshake bundle for gcd_req_queue: request channel, GCD core drive/completion, result channel.
// The master side is the environment and the slave side is the queue.
interface gcd_req_queue_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       gcd_start;
    logic [7:0] gcd_a;
    logic [7:0] gcd_b;
    logic       gcd_done;
    logic [7:0] gcd_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_res;
    logic       out_err;

    modport master (
        output in_valid, in_a, in_b, gcd_done, gcd_res, out_ready,
        input  in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_res, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, gcd_done, gcd_res, out_ready,
        output in_ready, gcd_start, gcd_a, gcd_b, out_valid, out_res, out_err
    );
endinterface

// File: rtl/gcd_req_queue.sv
// Operand-pair FIFO feeding a GCD core, with completion timeout and a held result channel.
// Optional macro GCD_ZERO_BYPASS_EN answers pairs with a zero operand without using the core.
module gcd_req_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    gcd_req_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       gcd_a_q, gcd_a_d;
    logic [7:0]       gcd_b_q, gcd_b_d;
    logic [7:0]       out_res_q, out_res_d;
    logic             out_err_q, out_err_d;
    logic [7:0]       timer_q, timer_d;

    logic             full;
    logic             empty;
    logic             in_ready;
    logic             push;
    logic             take_head;
    logic [7:0]       head_a;
    logic [7:0]       head_b;
    logic             head_zero;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !rst;
    assign push     = bus.in_valid && in_ready;
    assign head_a   = mem_q[rd_ptr_q][15:8];
    assign head_b   = mem_q[rd_ptr_q][7:0];

`ifdef GCD_ZERO_BYPASS_EN
    assign head_zero = (head_a == 8'd0) || (head_b == 8'd0);
`else
    assign head_zero = 1'b0;
`endif

    // Fullness comes from the registered count, so a same-cycle pop never opens a slot for the push.
    always_comb begin : fifo_next
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_a, bus.in_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (take_head) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, take_head})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        gcd_a_d   = gcd_a_q;
        gcd_b_d   = gcd_b_q;
        out_res_d = out_res_q;
        out_err_d = out_err_q;
        timer_d   = timer_q;
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = 8'd0;
            end
            WAIT: begin
                if (bus.gcd_done) begin
                    out_res_d = bus.gcd_res;
                    out_err_d = 1'b0;
                    state_d   = HOLD;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    out_res_d = 8'd0;
                    out_err_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Taking a new head overrides the plain IDLE/HOLD transitions above.
        if (take_head) begin
            if (head_zero) begin
                out_res_d = head_a | head_b;
                out_err_d = 1'b0;
                state_d   = HOLD;
            end else begin
                gcd_a_d = head_a;
                gcd_b_d = head_b;
                state_d = ISSUE;
            end
        end
    end

    always_comb begin : fsm_out
        take_head     = !empty && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
        bus.gcd_start = (state_q == ISSUE);
        bus.out_valid = (state_q == HOLD);
        bus.in_ready  = in_ready;
        bus.gcd_a     = gcd_a_q;
        bus.gcd_b     = gcd_b_q;
        bus.out_res   = out_res_q;
        bus.out_err   = out_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            gcd_a_q   <= 8'd0;
            gcd_b_q   <= 8'd0;
            out_res_q <= 8'd0;
            out_err_q <= 1'b0;
            timer_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            gcd_a_q   <= gcd_a_d;
            gcd_b_q   <= gcd_b_d;
            out_res_q <= out_res_d;
            out_err_q <= out_err_d;
            timer_q   <= timer_d;
        end
    end

    // Storage needs no reset: emptiness is defined entirely by the pointers and count.
    always_ff @(posedge clk) begin : fifo_mem
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_gcd_req_queue.sv
// Self-checking bench for gcd_req_queue: queue-based result model, behavioural GCD core,
// and directed scenarios with hand-computed results.
module tb_gcd_req_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         dly;
    } pair_t;

    logic clk;
    logic rst;
    gcd_req_queue_if bus ();

    gcd_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    int         start_cnt  = 0;
    int         stim_delay = 0;
    int         core_cnt   = 0;
    logic       busy       = 1'b0;
    logic [7:0] cur_a      = 8'd0;
    logic [7:0] cur_b      = 8'd0;
    pair_t      issue_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] res_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gcd(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] t;
        a = x;
        b = y;
        while (b != 8'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: bound expired or event missing (t=%0t)", name, $time);
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int dly);
        logic accepted;
        accepted   = 1'b0;
        stim_delay = dly;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int n = 0; n < 200 && !accepted; n++) begin
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) failNow("push_accept");
    endtask

    task automatic waitResults(input int n, input int maxCycles);
        int k;
        k = 0;
        while (res_log.size() < n && k < maxCycles) begin
            @(negedge clk);
            k++;
        end
        if (res_log.size() < n) failNow("result_wait");
    endtask

    task automatic waitStart(input int maxCycles);
        int k;
        k = 0;
        while (!bus.gcd_start && k < maxCycles) begin
            @(negedge clk);
            k++;
        end
        if (!bus.gcd_start) failNow("start_wait");
    endtask

    // Core model plus scoreboard: predicts each result from the accepted pair and the core delay.
    always @(negedge clk) begin : monitor
        pair_t      p;
        logic [8:0] e;
        logic       bypass;
        if (core_cnt > 0) begin
            core_cnt--;
            bus.gcd_done = (core_cnt == 0);
        end else begin
            bus.gcd_done = 1'b0;
        end
        if (rst) begin
            checkOutput("rst_outputs",
                {bus.gcd_start, bus.out_valid, bus.out_err, bus.in_ready, bus.gcd_a, bus.gcd_b, bus.out_res}, 32'd0);
            issue_q.delete();
            exp_q.delete();
            busy = 1'b0;
        end else begin
            if (bus.gcd_start) begin
                start_cnt++;
                checkOutput("start_during_hold", bus.out_valid, 0);
                if (issue_q.size() == 0) begin
                    failNow("unexpected_start");
                end else begin
                    p = issue_q.pop_front();
                    checkOutput("gcd_a", bus.gcd_a, p.a);
                    checkOutput("gcd_b", bus.gcd_b, p.b);
                    cur_a = p.a;
                    cur_b = p.b;
                    busy  = 1'b1;
                    if (p.dly > 0) begin
                        core_cnt    = p.dly;
                        bus.gcd_res = gcd(p.a, p.b);
                    end
                end
            end else if (busy && !bus.out_valid) begin
                checkOutput("gcd_a_stable", bus.gcd_a, cur_a);
                checkOutput("gcd_b_stable", bus.gcd_b, cur_b);
            end
            checkOutput("in_ready", bus.in_ready, issue_q.size() < DEPTH);
            if (bus.out_valid) begin
                busy = 1'b0;
                if (exp_q.size() == 0) begin
                    failNow("spurious_out_valid");
                end else begin
                    checkOutput("out_res", bus.out_res, exp_q[0][7:0]);
                    checkOutput("out_err", bus.out_err, exp_q[0][8]);
                    if (bus.out_ready) begin
                        res_log.push_back({bus.out_err, bus.out_res});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                bypass = 1'b0;
`ifdef GCD_ZERO_BYPASS_EN
                bypass = (bus.in_a == 8'd0) || (bus.in_b == 8'd0);
`endif
                if (bypass) begin
                    e = {1'b0, bus.in_a | bus.in_b};
                end else begin
                    p.a   = bus.in_a;
                    p.b   = bus.in_b;
                    p.dly = stim_delay;
                    issue_q.push_back(p);
                    if (stim_delay >= 1 && stim_delay <= TIMEOUT) e = {1'b0, gcd(bus.in_a, bus.in_b)};
                    else e = {1'b1, 8'd0};
                end
                exp_q.push_back(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        failNow("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : main
        int base;
        int s0;
        int n;
        int valid_seen;
        logic [7:0] mix_a [6];
        logic [7:0] mix_b [6];
        int         mix_d [6];
        mix_a = '{8'd12, 8'd100, 8'd255, 8'd64, 8'd7,  8'd81};
        mix_b = '{8'd18, 8'd75,  8'd17,  8'd48, 8'd13, 8'd27};
        mix_d = '{1, 4, 2, 7, 1, 3};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_in_ready", bus.in_ready, 0);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_gcd_start", bus.gcd_start, 0);
        checkOutput("reset_out_res", bus.out_res, 0);
        nextCycle(3);
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", bus.in_ready, 1);
        nextCycle(1);

        $display("[TB] basic pair (5,20) and issue latency");
        applyStimulus(8'd5, 8'd20, 3);
        @(negedge clk);
        checkOutput("latency_no_start_yet", bus.gcd_start, 0);
        @(negedge clk);
        checkOutput("latency_start", bus.gcd_start, 1);
        checkOutput("latency_gcd_a", bus.gcd_a, 5);
        checkOutput("latency_gcd_b", bus.gcd_b, 20);
        waitResults(1, 60);
        checkOutput("basic_result", res_log[0], {1'b0, 8'd5});
        checkOutput("basic_single_start", start_cnt, 1);
        nextCycle(1);
        checkOutput("idle_out_valid", bus.out_valid, 0);

        $display("[TB] zero operand pair (0,12)");
        base = res_log.size();
        s0   = start_cnt;
        applyStimulus(8'd0, 8'd12, 2);
        waitResults(base + 1, 60);
        checkOutput("zero_result", res_log[base], {1'b0, 8'd12});
`ifdef GCD_ZERO_BYPASS_EN
        checkOutput("zero_starts", start_cnt - s0, 0);
`else
        checkOutput("zero_starts", start_cnt - s0, 1);
`endif
        nextCycle(1);

        $display("[TB] timeout with late completion");
        base = res_log.size();
        bus.out_ready = 1'b0;
        applyStimulus(8'd27, 8'd18, 20);
        waitStart(10);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", n, 17);
        checkOutput("timeout_res", bus.out_res, 0);
        checkOutput("timeout_err", bus.out_err, 1);
        repeat (6) @(negedge clk);
        checkOutput("late_done_res", bus.out_res, 0);
        checkOutput("late_done_err", bus.out_err, 1);
        nextCycle(1);
        bus.out_ready = 1'b1;
        waitResults(base + 1, 20);
        checkOutput("timeout_logged", res_log[base], {1'b1, 8'd0});
        nextCycle(1);

        $display("[TB] fill queue behind a stalled core");
        base = res_log.size();
        bus.out_ready = 1'b0;
        applyStimulus(8'd9, 8'd6, 0);
        applyStimulus(8'd30, 8'd7, 3);
        applyStimulus(8'd140, 8'd20, 2);
        applyStimulus(8'd48, 8'd18, 5);
        applyStimulus(8'd17, 8'd17, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd1;
        bus.in_b     = 8'd1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("full_in_ready", bus.in_ready, 0);
            nextCycle(1);
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_hold_reached", bus.out_valid, 1);
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_res_stable", bus.out_res, 0);
            checkOutput("hold_err_stable", bus.out_err, 1);
            checkOutput("hold_valid", bus.out_valid, 1);
        end
        checkOutput("hold_no_start", start_cnt - s0, 0);
        nextCycle(1);
        bus.out_ready = 1'b1;
        waitResults(base + 5, 200);
        checkOutput("order_0", res_log[base],     {1'b1, 8'd0});
        checkOutput("order_1", res_log[base + 1], {1'b0, 8'd1});
        checkOutput("order_2", res_log[base + 2], {1'b0, 8'd20});
        checkOutput("order_3", res_log[base + 3], {1'b0, 8'd6});
        checkOutput("order_4", res_log[base + 4], {1'b0, 8'd17});
        nextCycle(1);

        $display("[TB] mixed stream");
        base = res_log.size();
        for (int i = 0; i < 6; i++) applyStimulus(mix_a[i], mix_b[i], mix_d[i]);
        waitResults(base + 6, 300);
        checkOutput("mix_1", res_log[base + 1], {1'b0, 8'd25});
        checkOutput("mix_5", res_log[base + 5], {1'b0, 8'd27});
        nextCycle(1);

        $display("[TB] reset during WAIT");
        base = res_log.size();
        applyStimulus(8'd12, 8'd8, 10);
        waitStart(10);
        nextCycle(3);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_gcd_start", bus.gcd_start, 0);
        checkOutput("midrst_gcd_a", bus.gcd_a, 0);
        checkOutput("midrst_gcd_b", bus.gcd_b, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_out_res", bus.out_res, 0);
        checkOutput("midrst_out_err", bus.out_err, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        nextCycle(2);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1);
        valid_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) valid_seen++;
        end
        checkOutput("post_rst_no_valid", valid_seen, 0);
        checkOutput("post_rst_no_result", res_log.size(), base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gcd_req_queue.md
GCD_REQ_QUEUE -- requirements
Module: gcd_req_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, operand FIFO depth in entries; power of two, minimum 2.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles allowed for gcd_done; range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 8) and in_b (input, 8), forming the operand-pair request channel.
REQ-006 The block SHALL have ports gcd_start (output, 1), gcd_a (output, 8) and gcd_b (output, 8), the drive to the downstream GCD core.
REQ-007 The block SHALL have ports gcd_done (input, 1) and gcd_res (input, 8), the GCD core completion flag and result.
REQ-008 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_res (output, 8) and out_err (output, 1), forming the result channel.

Function
REQ-009 Request accept: a pair SHALL be pushed when in_valid and in_ready are both high at a clock edge; in_ready = not full.
REQ-010 A push into a full FIFO SHALL be impossible; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-011 Simultaneous push and pop SHALL leave the occupancy count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-012 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD; the reset state SHALL be IDLE.
REQ-013 From IDLE with the FIFO non-empty, the FSM SHALL pop the head pair, register it into gcd_a/gcd_b and enter ISSUE.
REQ-014 In ISSUE, gcd_start SHALL be high for exactly one cycle, and the next state SHALL be WAIT.
REQ-015 gcd_a and gcd_b SHALL remain stable from ISSUE until WAIT exits.
REQ-016 In WAIT, gcd_done high SHALL capture gcd_res into out_res, clear out_err and move the FSM to HOLD.
REQ-017 gcd_done SHALL be ignored in IDLE, ISSUE and HOLD.
REQ-018 Timeout: if TIMEOUT WAIT cycles elapse without gcd_done, the block SHALL set out_res=0 and out_err=1 and enter HOLD; a gcd_done arriving later SHALL be discarded.
REQ-019 In HOLD, out_valid SHALL be high and out_res/out_err SHALL be held stable until out_ready is sampled high.
REQ-020 On the HOLD handshake, the FSM SHALL pop the next pair and go to ISSUE if the FIFO is non-empty; otherwise it SHALL go to IDLE.
REQ-021 out_valid SHALL be low in every state other than HOLD.
REQ-022 Latency: for a pair pushed at edge k into an empty, idle block, gcd_start SHALL be high in the cycle following edge k+1.
REQ-023 Ordering: results SHALL leave in the same order as their pairs were accepted; exactly one result SHALL be produced per accepted pair.

Reset
REQ-024 Asserting rst SHALL immediately, without a clock, empty the FIFO, zero both pointers and the count, and force state IDLE.
REQ-025 During rst, outputs SHALL be: gcd_start=0, gcd_a=0, gcd_b=0, out_valid=0, out_res=0, out_err=0, in_ready=0.
REQ-026 After rst deasserts, in_ready SHALL be 1.
REQ-027 A reset asserted in the middle of an operation SHALL abandon the in-flight pair without producing a result.

Configuration
REQ-028 The macro GCD_ZERO_BYPASS_EN SHALL control zero-operand bypass.
REQ-029 With GCD_ZERO_BYPASS_EN defined, a head pair with a==0 or b==0 SHALL be popped without gcd_start and SHALL go directly to HOLD with out_res = a OR b and out_err=0.
REQ-030 Without GCD_ZERO_BYPASS_EN, zero-operand pairs SHALL be issued to the core like any other pair.

Verification
REQ-031 Push (5,20); core model raises done with res=5 after 3 cycles -> single gcd_start pulse with gcd_a=5, gcd_b=20; then out_valid=1, out_res=5, out_err=0.
REQ-032 DEPTH=4, out_ready=0, core never completes; push 5 pairs back-to-back -> 1 in flight plus 4 queued, in_ready=0 on the 6th attempt, nothing lost; releasing the core yields results in push order (e.g. (30,7)->1, (140,20)->20).
REQ-033 TIMEOUT=16, gcd_done held at 0 -> out_valid=1, out_err=1, out_res=0 after 16 WAIT cycles; a late gcd_done with res=9 does not alter out_res.
REQ-034 Push (0,12) -> with the macro defined: out_res=12, no gcd_start; without the macro: gcd_start issued with gcd_a=0, gcd_b=12.
REQ-035 Assert rst during WAIT -> all outputs zero at once, FIFO empty; a gcd_done raised after reset release produces no out_valid.
REQ-036 Hold out_ready low for 10 cycles in HOLD -> out_res and out_err stay constant and no further gcd_start occurs until the handshake.
